// File: rtl/spmv_mem_arbiter.sv
// spmv_mem_arbiter: NUM_CH-channel memory request arbiter and response router.
// Per-channel request FIFO, fixed or round-robin grant, registered issue to MC.
// Ports: arb_mode, ch_push/st/addr/d/sub_tag in, ch_stall out (request side);
//   req_mem_ld/st/addr/d_or_tag out, req_mem_stall in (MC issue side);
//   rsp_mem_push/tag/q in, rsp_mem_stall out (MC response side);
//   ch_rsp_push/sub_tag/q out, ch_rsp_stall in; busy, overflow status.
// Optional macro SPMV_MEM_ARB_PERF_EN adds perf_grants and perf_stall_cycles.
module spmv_mem_arbiter #(
    parameter int NUM_CH    = 3,
    parameter int DEPTH     = 32,
    parameter int AF_COUNT  = 8,
    parameter int SUB_TAG_W = 2,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        arb_mode,
    input  logic [NUM_CH-1:0]           ch_push,
    input  logic [NUM_CH-1:0]           ch_st,
    input  logic [NUM_CH*48-1:0]        ch_addr,
    input  logic [NUM_CH*64-1:0]        ch_d,
    input  logic [NUM_CH*SUB_TAG_W-1:0] ch_sub_tag,
    output logic [NUM_CH-1:0]           ch_stall,
    output logic                        req_mem_ld,
    output logic                        req_mem_st,
    output logic [47:0]                 req_mem_addr,
    output logic [63:0]                 req_mem_d_or_tag,
    input  logic                        req_mem_stall,
    input  logic                        rsp_mem_push,
    input  logic [CH_W+SUB_TAG_W-1:0]   rsp_mem_tag,
    input  logic [63:0]                 rsp_mem_q,
    output logic                        rsp_mem_stall,
    output logic [NUM_CH-1:0]           ch_rsp_push,
    output logic [SUB_TAG_W-1:0]        ch_rsp_sub_tag,
    output logic [63:0]                 ch_rsp_q,
    input  logic [NUM_CH-1:0]           ch_rsp_stall,
    output logic                        busy,
    output logic                        overflow
`ifdef SPMV_MEM_ARB_PERF_EN
    ,
    output logic [NUM_CH*32-1:0]        perf_grants,
    output logic [31:0]                 perf_stall_cycles
`endif
);
    localparam int PW    = $clog2(DEPTH);
    localparam int ENT_W = 1 + 48 + 64;

    // Entry: {st, addr, payload}; payload is store data or the load tag,
    // so the issue path never needs to know which channel it came from.
    logic [ENT_W-1:0]  r_mem [NUM_CH][DEPTH];
    logic [PW-1:0]     r_wptr [NUM_CH];
    logic [PW-1:0]     r_rptr [NUM_CH];
    logic [PW:0]       r_cnt [NUM_CH];
    logic [PW:0]       w_cnt_nxt [NUM_CH];
    logic [63:0]       w_tag [NUM_CH];
    logic [ENT_W-1:0]  w_entry [NUM_CH];
    logic [ENT_W-1:0]  w_rd;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_acc;
    logic [NUM_CH-1:0] w_drop;
    logic [NUM_CH-1:0] r_ch_stall;
    logic              r_stall;
    logic [CH_W-1:0]   r_rr;
    logic              w_gnt_vld;
    logic [CH_W-1:0]   w_gnt_ch;
    int                w_idx;
    logic              r_ld;
    logic              r_st;
    logic [47:0]       r_addr;
    logic [63:0]       r_dt;
    logic              r_ovf;
    logic [NUM_CH-1:0] r_rsp_push;
    logic [SUB_TAG_W-1:0] r_rsp_sub;
    logic [63:0]       r_rsp_q;
    logic              r_rsp_stall;
    logic [CH_W-1:0]   w_rsp_ch;
    logic              w_rsp_ok;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_empty[i] = (r_cnt[i] == '0);
            w_full[i]  = (r_cnt[i] == (PW+1)'(DEPTH));
            w_tag[i]   = '0;
            w_tag[i][CH_W-1:0] = CH_W'(i);
            w_tag[i][CH_W+:SUB_TAG_W] =
                ch_sub_tag[i*SUB_TAG_W+:SUB_TAG_W];
            w_entry[i] = {ch_st[i], ch_addr[i*48+:48],
                          ch_st[i] ? ch_d[i*64+:64] : w_tag[i]};
        end
    end

    // Search starts at rr_ptr in round-robin mode, at 0 in fixed mode.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_ch  = '0;
        w_idx     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = (arb_mode ? int'(r_rr) : 0) + k;
            if (w_idx >= NUM_CH) w_idx = w_idx - NUM_CH;
            if (!w_gnt_vld && !r_stall && !w_empty[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_ch  = CH_W'(w_idx);
            end
        end
    end

    // A full FIFO still accepts a push when it is popped the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_pop[i]  = w_gnt_vld && (w_gnt_ch == CH_W'(i));
            w_acc[i]  = ch_push[i] && (!w_full[i] || w_pop[i]);
            w_drop[i] = ch_push[i] && !w_acc[i];
            w_cnt_nxt[i] = r_cnt[i] + (PW+1)'(w_acc[i])
                         - (PW+1)'(w_pop[i]);
        end
    end

    always_comb begin
        w_rd = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_gnt_ch == CH_W'(i)) w_rd = r_mem[i][r_rptr[i]];
        end
    end

    assign w_rsp_ch = rsp_mem_tag[CH_W-1:0];
    assign w_rsp_ok = int'(w_rsp_ch) < NUM_CH;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_acc[i]) r_mem[i][r_wptr[i]] <= w_entry[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_wptr[i] <= '0;
                r_rptr[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_ch_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_acc[i]) r_wptr[i] <= r_wptr[i] + 1'b1;
                if (w_pop[i]) r_rptr[i] <= r_rptr[i] + 1'b1;
                r_cnt[i] <= w_cnt_nxt[i];
                r_ch_stall[i] <=
                    (DEPTH - int'(w_cnt_nxt[i])) <= AF_COUNT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall <= 1'b0;
            r_rr    <= '0;
            r_ld    <= 1'b0;
            r_st    <= 1'b0;
            r_addr  <= '0;
            r_dt    <= '0;
        end else begin
            r_stall <= req_mem_stall;
            if (w_gnt_vld) begin
                if (arb_mode) begin
                    r_rr <= (int'(w_gnt_ch) == NUM_CH - 1) ?
                            '0 : w_gnt_ch + 1'b1;
                end
                r_st   <= w_rd[ENT_W-1];
                r_ld   <= ~w_rd[ENT_W-1];
                r_addr <= w_rd[111:64];
                r_dt   <= w_rd[63:0];
            end else begin
                r_ld <= 1'b0;
                r_st <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_push  <= '0;
            r_rsp_sub   <= '0;
            r_rsp_q     <= '0;
            r_rsp_stall <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_rsp_stall <= |ch_rsp_stall;
            r_rsp_push  <= (rsp_mem_push && w_rsp_ok) ?
                           NUM_CH'(1) << w_rsp_ch : '0;
            if (rsp_mem_push) begin
                r_rsp_sub <= rsp_mem_tag[CH_W+:SUB_TAG_W];
                r_rsp_q   <= rsp_mem_q;
            end
            if ((|w_drop) || (rsp_mem_push && !w_rsp_ok)) r_ovf <= 1'b1;
        end
    end

`ifdef SPMV_MEM_ARB_PERF_EN
    logic [31:0] r_perf_g [NUM_CH];
    logic [31:0] r_perf_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) r_perf_g[i] <= '0;
            r_perf_s <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_pop[i] && (r_perf_g[i] != '1))
                    r_perf_g[i] <= r_perf_g[i] + 1'b1;
            end
            if (r_stall && !(&w_empty)) r_perf_s <= r_perf_s + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_perf
        assign perf_grants[g*32+:32] = r_perf_g[g];
    end
    assign perf_stall_cycles = r_perf_s;
`endif

    assign ch_stall         = r_ch_stall;
    assign req_mem_ld       = r_ld;
    assign req_mem_st       = r_st;
    assign req_mem_addr     = r_addr;
    assign req_mem_d_or_tag = r_dt;
    assign rsp_mem_stall    = r_rsp_stall;
    assign ch_rsp_push      = r_rsp_push;
    assign ch_rsp_sub_tag   = r_rsp_sub;
    assign ch_rsp_q         = r_rsp_q;
    assign busy             = !(&w_empty) || r_ld || r_st;
    assign overflow         = r_ovf;
endmodule
